// File: rtl/btn_run_ctrl.sv
// Button front-end (sync + debounce + rise pulse per channel) and a
// start/abort/done run controller with a cycle counter and status LED bank.

module btn_run_ctrl_db #(
  parameter int DEBOUNCE_CYCLES = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic           s1_q, s2_q, level_q, rise_q;
  logic [DBW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      rise_q <= 1'b0;
      if (s2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        // rise pulse lands in the same cycle the new high level appears
        level_q <= s2_q;
        rise_q  <= s2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + DBW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
endmodule

module btn_run_ctrl #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 50,
  parameter int RUN_CYCLES      = 1000,
  parameter int CNT_W           = 20,
  parameter int LED_W           = 16,
  parameter int LED_SHIFT       = 4
) (
  input  logic             CLK100MHZ,
  input  logic             BTNreset,
  input  logic [N_BTN-1:0] BTN,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic             run,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [LED_W-1:0] LED
);
  if (N_BTN < 2 || DEBOUNCE_CYCLES < 2 || LED_W < 3) begin : g_bad_params
    $error("btn_run_ctrl: N_BTN>=2, DEBOUNCE_CYCLES>=2, LED_W>=3 required");
  end
  if (RUN_CYCLES < 1 || longint'(RUN_CYCLES) > (64'd1 << CNT_W) - 64'd1) begin : g_bad_run
    $error("btn_run_ctrl: RUN_CYCLES must be in 1 .. 2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_END  = CNT_W'(RUN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  btn_run_ctrl_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [N_BTN-1:0] (
    .clk_i   (CLK100MHZ),
    .rst_i   (BTNreset),
    .raw_i   (BTN),
    .level_o (btn_level),
    .rise_o  (btn_rise)
  );

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LED_W-3:0] led_prog;
  logic             run_q, done_q;
  logic [LED_W-1:0] led_q;

  wire start_w = btn_rise[0];
  wire abort_w = btn_rise[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start_w && !abort_w) begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: if (abort_w) begin
        state_d = IDLE;
      end else if (cnt_q == RUN_LAST) begin
        state_d = DONE;
        cnt_d   = RUN_END;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      DONE: if (abort_w) begin
        state_d = IDLE;
      end else if (start_w) begin
        state_d = RUN;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are built from next-state values so they share the state's cycle
  assign led_prog = (LED_W-2)'({{LED_W{1'b0}}, cnt_d} >> LED_SHIFT);

  always_ff @(posedge CLK100MHZ) begin
    if (BTNreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      led_q   <= {state_d == RUN, state_d == DONE, led_prog};
    end
  end

  assign run         = run_q;
  assign done        = done_q;
  assign cycle_count = cnt_q;
  assign LED         = led_q;
endmodule

// File: tb/tb_btn_run_ctrl.sv
// Directed bench for btn_run_ctrl at default parameters (debounce 50, run 1000).

module tb_btn_run_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  btn;
  logic [1:0]  btn_level, btn_rise;
  logic        run, done;
  logic [19:0] cycle_count;
  logic [15:0] LED;

  int checks = 0;
  int errors = 0;

  btn_run_ctrl dut (
    .CLK100MHZ   (clk),
    .BTNreset    (rst),
    .BTN         (btn),
    .btn_level   (btn_level),
    .btn_rise    (btn_rise),
    .run         (run),
    .done        (done),
    .cycle_count (cycle_count),
    .LED         (LED)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    btn = 2'b11;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({btn_level, btn_rise, run, done, cycle_count, LED} !== '0) begin
      errors++;
      $display("FAIL reset_outputs lvl=%b rise=%b run=%b done=%b cnt=%0d led=%h required all zero",
               btn_level, btn_rise, run, done, cycle_count, LED);
    end
    rst = 1'b0;
    repeat (51) tick();
    checks++;
    if (btn_level !== 2'b00) begin
      errors++; $display("FAIL reset_lvl_edge51 got %b required 00", btn_level);
    end
    tick();
    checks++;
    if (btn_level !== 2'b11 || btn_rise !== 2'b11) begin
      errors++; $display("FAIL reset_lvl_edge52 lvl=%b rise=%b required 11/11", btn_level, btn_rise);
    end
    tick();
    checks++;
    if (btn_rise !== 2'b00 || run !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_simul_idle rise=%b run=%b done=%b required 00/0/0", btn_rise, run, done);
    end
    btn = 2'b00;
    begin
      bit saw_rise = 0;
      repeat (60) begin
        tick();
        if (btn_rise !== 2'b00) saw_rise = 1;
      end
      checks++;
      if (saw_rise || btn_level !== 2'b00) begin
        errors++; $display("FAIL reset_release rise_seen=%0d lvl=%b required 0/00", saw_rise, btn_level);
      end
    end
  endtask

  task automatic test_bounce();
    bit bad = 0;
    for (int p = 0; p < 200; p++) begin
      btn[0] = ((p % 15) < 10);
      tick();
      if (btn_level[0] !== 1'b0 || btn_rise !== 2'b00 || run !== 1'b0) bad = 1;
    end
    btn = 2'b00;
    repeat (60) tick();
    checks++;
    if (bad || btn_level !== 2'b00 || run !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL bounce_rejected bad=%0d lvl=%b run=%b done=%b required 0/00/0/0",
                         bad, btn_level, run, done);
    end
  endtask

  task automatic test_start_run();
    int n = 0;
    int t;
    btn[0] = 1'b1;
    repeat (51) tick();
    checks++;
    if (btn_level[0] !== 1'b0) begin
      errors++; $display("FAIL start_lvl_edge51 got %b required 0", btn_level[0]);
    end
    tick();
    checks++;
    if (btn_level[0] !== 1'b1 || btn_rise !== 2'b01 || run !== 1'b0) begin
      errors++; $display("FAIL start_edge52 lvl=%b rise=%b run=%b required 1/01/0", btn_level[0], btn_rise, run);
    end
    tick();
    checks++;
    if (run !== 1'b1 || cycle_count !== 20'd0 || btn_rise !== 2'b00 || LED !== 16'h8000) begin
      errors++; $display("FAIL start_edge53 run=%b cnt=%0d rise=%b led=%h required 1/0/00/8000",
                         run, cycle_count, btn_rise, LED);
    end
    t = 53;
    while (run === 1'b1 && n < 1100) begin
      n++;
      tick();
      t++;
      if (t == 70) btn[0] = 1'b0;
    end
    checks++;
    if (n != 1000) begin
      errors++; $display("FAIL run_length got %0d cycles required 1000", n);
    end
    checks++;
    if (done !== 1'b1 || run !== 1'b0 || cycle_count !== 20'd1000 || LED !== 16'h403E) begin
      errors++; $display("FAIL run_done done=%b run=%b cnt=%0d led=%h required 1/0/1000/403e",
                         done, run, cycle_count, LED);
    end
    repeat (10) tick();
    checks++;
    if (done !== 1'b1 || cycle_count !== 20'd1000) begin
      errors++; $display("FAIL done_hold done=%b cnt=%0d required 1/1000", done, cycle_count);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    btn = 2'b01;
    repeat (60) tick();
    btn = 2'b00;
    while (cycle_count !== 20'd300 && n < 1100) begin n++; tick(); end
    checks++;
    if (run !== 1'b1 || cycle_count !== 20'd300) begin
      errors++; $display("FAIL abort_reach300 run=%b cnt=%0d required 1/300", run, cycle_count);
    end
    btn[1] = 1'b1;
    repeat (52) tick();
    checks++;
    if (btn_rise !== 2'b10 || run !== 1'b1 || cycle_count !== 20'd352) begin
      errors++; $display("FAIL abort_rise rise=%b run=%b cnt=%0d required 10/1/352", btn_rise, run, cycle_count);
    end
    tick();
    checks++;
    if (run !== 1'b0 || done !== 1'b0 || cycle_count !== 20'd352 || LED !== 16'h0016) begin
      errors++; $display("FAIL abort_idle run=%b done=%b cnt=%0d led=%h required 0/0/352/0016",
                         run, done, cycle_count, LED);
    end
    repeat (7) tick();
    btn = 2'b00;
    repeat (60) tick();
    checks++;
    if (cycle_count !== 20'd352 || run !== 1'b0) begin
      errors++; $display("FAIL abort_hold cnt=%0d run=%b required 352/0", cycle_count, run);
    end
    btn[0] = 1'b1;
    repeat (53) tick();
    checks++;
    if (run !== 1'b1 || cycle_count !== 20'd0) begin
      errors++; $display("FAIL restart run=%b cnt=%0d required 1/0", run, cycle_count);
    end
    repeat (7) tick();
    btn = 2'b00;
    n = 0;
    while (done !== 1'b1 && n < 1100) begin n++; tick(); end
    checks++;
    if (done !== 1'b1 || cycle_count !== 20'd1000) begin
      errors++; $display("FAIL restart_done done=%b cnt=%0d required 1/1000", done, cycle_count);
    end
  endtask

  task automatic test_simul();
    btn = 2'b11;
    repeat (52) tick();
    checks++;
    if (btn_rise !== 2'b11 || done !== 1'b1) begin
      errors++; $display("FAIL simul_rise rise=%b done=%b required 11/1", btn_rise, done);
    end
    tick();
    checks++;
    if (run !== 1'b0 || done !== 1'b0 || cycle_count !== 20'd1000 || LED !== 16'h003E) begin
      errors++; $display("FAIL simul_abort run=%b done=%b cnt=%0d led=%h required 0/0/1000/003e",
                         run, done, cycle_count, LED);
    end
    repeat (7) tick();
    btn = 2'b00;
    repeat (60) tick();
    checks++;
    if (run !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL simul_stay_idle run=%b done=%b required 0/0", run, done);
    end
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    btn = 2'b01;
    repeat (53) tick();
    checks++;
    if (run !== 1'b1 || cycle_count !== 20'd0) begin
      errors++; $display("FAIL midrun_start run=%b cnt=%0d required 1/0", run, cycle_count);
    end
    while (cycle_count !== 20'd500 && n < 1100) begin n++; tick(); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (run !== 1'b0 || done !== 1'b0 || cycle_count !== 20'd0 || LED !== 16'h0000 || btn_level !== 2'b00) begin
      errors++; $display("FAIL midrun_reset run=%b done=%b cnt=%0d led=%h lvl=%b required 0/0/0/0000/00",
                         run, done, cycle_count, LED, btn_level);
    end
    begin
      int rises = 0;
      for (int e = 1; e <= 52; e++) begin
        tick();
        if (btn_rise[0] === 1'b1) rises++;
      end
      checks++;
      if (rises != 1 || btn_rise[0] !== 1'b1) begin
        errors++; $display("FAIL midrun_redebounce rises=%0d rise_at52=%b required 1/1", rises, btn_rise[0]);
      end
    end
    tick();
    checks++;
    if (btn_rise[0] !== 1'b0 || run !== 1'b1 || cycle_count !== 20'd0) begin
      errors++; $display("FAIL midrun_newrun rise=%b run=%b cnt=%0d required 0/1/0", btn_rise[0], run, cycle_count);
    end
    btn = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    btn = 2'b00;
    test_reset();
    test_bounce();
    test_start_run();
    test_abort();
    test_simul();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
